// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - state codes and prescaler threshold helper for the ADSR envelope generator
package adsr_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  // (thr0+1)*2**k - 1 with k clamped to max_idx, saturating at the counter's all-ones value
  function automatic logic [63:0] step_thr(input int idx, input int thr0,
                                           input int nbit_cnt, input int max_idx);
    int          k;
    logic [63:0] lim;
    logic [63:0] v;
    k   = (idx > max_idx) ? max_idx : idx;
    lim = (nbit_cnt >= 64) ? '1 : ((64'd1 << nbit_cnt) - 64'd1);
    v   = ((64'(thr0) + 64'd1) << k) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/adsr_env_gen_if.sv
// rtl/adsr_env_gen_if.sv - voice-side bundle: gate, envelope settings and envelope outputs
interface adsr_env_gen_if #(
  parameter int NBIT_DATA = 8,
  parameter int NBIT_IDX  = 4
);
  logic                 gate_i;
  logic                 legato_i;
  logic [NBIT_IDX-1:0]  a_t_idx;
  logic [NBIT_IDX-1:0]  h_t_idx;
  logic [NBIT_IDX-1:0]  d_t_idx;
  logic [NBIT_DATA-1:0] s_level;
  logic [NBIT_IDX-1:0]  r_t_idx;
  logic [NBIT_DATA-1:0] dout;
  logic                 vout;
  logic [2:0]           phase_o;
  logic                 eoc_o;

  modport master (
    output gate_i, legato_i, a_t_idx, h_t_idx, d_t_idx, s_level, r_t_idx,
    input  dout, vout, phase_o, eoc_o
  );

  modport slave (
    input  gate_i, legato_i, a_t_idx, h_t_idx, d_t_idx, s_level, r_t_idx,
    output dout, vout, phase_o, eoc_o
  );
endinterface

// File: rtl/adsr_step_prescaler.sv
// rtl/adsr_step_prescaler.sv - step prescaler: counts 0..thr, flags tc at the top, clears on request
module adsr_step_prescaler #(
  parameter int NBIT_CNT = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NBIT_CNT-1:0] thr,
  input  logic                clr,
  output logic                tc
);
  logic [NBIT_CNT-1:0] cnt;

  // >= keeps the counter from running past a threshold that shrank mid-phase
  assign tc = (cnt >= thr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/adsr_env_gen.sv
// rtl/adsr_env_gen.sv - ADSR envelope generator top: FSM, envelope value register, eoc pulse
// Optional HOLD phase after attack is enabled by defining ADSR_HOLD_EN.
module adsr_env_gen
  import adsr_pkg::*;
#(
  parameter int NBIT_DATA = 8,
  parameter int NBIT_IDX  = 4,
  parameter int MAX_IDX   = 14,
  parameter int NBIT_CNT  = 28,
  parameter int STEP_THR0 = 190
) (
  input logic           clk,
  input logic           rst,
  adsr_env_gen_if.slave bus
);
  localparam logic [NBIT_DATA-1:0] VMAX = '1;

  state_t               state;
  state_t               state_nxt;
  logic [NBIT_DATA-1:0] val;
  logic [NBIT_DATA-1:0] val_nxt;
  logic                 eoc;
  logic [NBIT_IDX-1:0]  idx;
  logic [NBIT_CNT-1:0]  thr;
  logic                 tc;
  logic                 clr;

  always_comb begin
    idx = '0;
    case (state)
      S_ATTACK:  idx = bus.a_t_idx;
      S_DECAY:   idx = bus.d_t_idx;
      S_RELEASE: idx = bus.r_t_idx;
`ifdef ADSR_HOLD_EN
      S_HOLD:    idx = bus.h_t_idx;
`endif
      default:   idx = '0;
    endcase
  end

  assign thr = NBIT_CNT'(step_thr(int'(idx), STEP_THR0, NBIT_CNT, MAX_IDX));

  // Gate changes are checked first in every phase so they win over a same-cycle tc
  always_comb begin
    state_nxt = state;
    val_nxt   = val;
    case (state)
      S_IDLE: begin
        val_nxt = '0;
        if (bus.gate_i) state_nxt = S_ATTACK;
      end
      S_ATTACK: begin
        if (!bus.gate_i) begin
          state_nxt = S_RELEASE;
        end else if (tc) begin
          if (val == VMAX) begin
`ifdef ADSR_HOLD_EN
            state_nxt = S_HOLD;
`else
            state_nxt = S_DECAY;
`endif
          end else begin
            val_nxt = val + 1'b1;
          end
        end
      end
`ifdef ADSR_HOLD_EN
      S_HOLD: begin
        if (!bus.gate_i)  state_nxt = S_RELEASE;
        else if (tc)      state_nxt = S_DECAY;
      end
`endif
      S_DECAY: begin
        if (!bus.gate_i)               state_nxt = S_RELEASE;
        else if (val <= bus.s_level)   state_nxt = S_SUSTAIN;
        else if (tc)                   val_nxt   = val - 1'b1;
      end
      S_SUSTAIN: begin
        if (!bus.gate_i) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (bus.gate_i) begin
          state_nxt = S_ATTACK;
          if (!bus.legato_i) val_nxt = '0;
        end else if (val == '0) begin
          state_nxt = S_IDLE;
        end else if (tc) begin
          val_nxt = val - 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        val_nxt   = '0;
      end
    endcase
  end

  assign clr = (state_nxt != state) || (state == S_IDLE) || (state == S_SUSTAIN);

  adsr_step_prescaler #(.NBIT_CNT(NBIT_CNT)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .thr (thr),
    .clr (clr),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      val   <= '0;
      eoc   <= 1'b0;
    end else begin
      state <= state_nxt;
      val   <= val_nxt;
      eoc   <= (state == S_RELEASE) && !bus.gate_i && (val == '0);
    end
  end

  assign bus.dout    = val;
  assign bus.vout    = (state != S_IDLE);
  assign bus.phase_o = state;
  assign bus.eoc_o   = eoc;
endmodule
